scan_target_mux: RTL and testbench

SCAN_TARGET_MUX -- requirements
Module: scan_target_mux

---
 rtl/scan_target_mux.sv | 165 ++++++++++++++++
 tb/tb_scan_target_mux.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_target_mux.sv
// Scan-bus fan-out: routes one read/write at a time to one of NUM_TGT targets and returns a response.
// Optional build macro SCAN_MUX_TIMEOUT_EN adds a TIMEOUT-cycle limit on waiting for the target.
//
// state | meaning
// IDLE  | waiting for a scan request
// ISSUE | strobe cycle; the selected target is read or written
// WAIT  | waiting for the selected target's ready
// RESP  | scan_ready pulse with the response
module scan_target_mux #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scan_ren,
  input  logic                        scan_wen,
  input  logic [ADDR_W-1:0]           scan_addr,
  input  logic [DATA_W-1:0]           scan_wdata,
  output logic [DATA_W-1:0]           scan_rdata,
  output logic                        scan_ready,
  output logic                        scan_err,
  output logic                        scan_drop,
  output logic [(2**SEL_W)-1:0]       tgt_ren,
  output logic [(2**SEL_W)-1:0]       tgt_wen,
  output logic [ADDR_W-SEL_W-1:0]     tgt_addr,
  output logic [DATA_W-1:0]           tgt_wdata,
  input  logic [(2**SEL_W)*DATA_W-1:0] tgt_rdata,
  input  logic [(2**SEL_W)-1:0]       tgt_ready
);

  localparam int NUM_TGT = 2**SEL_W;
  localparam int LOC_W   = ADDR_W - SEL_W;

  if (TIMEOUT < 1 || SEL_W < 1 || SEL_W >= ADDR_W) begin : g_param_check
    $error("scan_target_mux: need TIMEOUT >= 1 and 1 <= SEL_W < ADDR_W");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, new_sel;
  logic               wr_q, wr_d;
  logic [LOC_W-1:0]   addr_d;
  logic [DATA_W-1:0]  wdata_d, rdata_d, sel_data;
  logic [NUM_TGT-1:0] ren_d, wen_d;
  logic               ready_d, err_d, drop_d, sel_rdy, req;

`ifdef SCAN_MUX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (sel_q == SEL_W'(k)) sel_data = tgt_rdata[k*DATA_W +: DATA_W];
    end
  end

  assign sel_rdy = tgt_ready[sel_q];
  assign req     = scan_ren | scan_wen;
  assign new_sel = scan_addr[ADDR_W-1 -: SEL_W];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    wr_d    = wr_q;
    addr_d  = tgt_addr;
    wdata_d = tgt_wdata;
    rdata_d = scan_rdata;
    ren_d   = '0;
    wen_d   = '0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    drop_d  = scan_drop;
`ifdef SCAN_MUX_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (scan_ren && scan_wen) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (req) begin
          state_d = ISSUE;
          sel_d   = new_sel;
          wr_d    = scan_wen;
          addr_d  = scan_addr[LOC_W-1:0];
          wdata_d = scan_wdata;
          if (scan_wen) wen_d[new_sel] = 1'b1;
          else          ren_d[new_sel] = 1'b1;
`ifdef SCAN_MUX_TIMEOUT_EN
          cnt_d   = CNT_W'(TIMEOUT - 1);
`endif
        end
      end
      ISSUE, WAIT: begin
        if (req) drop_d = 1'b1;
        // a ready in the expiry cycle takes priority over the timeout
        if (sel_rdy) begin
          state_d = RESP;
          ready_d = 1'b1;
          if (!wr_q) rdata_d = sel_data;
`ifdef SCAN_MUX_TIMEOUT_EN
        end else if (cnt_q == '0) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = cnt_q - CNT_W'(1);
`else
        end else begin
          state_d = WAIT;
`endif
        end
      end
      RESP: begin
        if (req) drop_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      tgt_addr   <= '0;
      tgt_wdata  <= '0;
      tgt_ren    <= '0;
      tgt_wen    <= '0;
      scan_rdata <= '0;
      scan_ready <= 1'b0;
      scan_err   <= 1'b0;
      scan_drop  <= 1'b0;
`ifdef SCAN_MUX_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      tgt_addr   <= addr_d;
      tgt_wdata  <= wdata_d;
      tgt_ren    <= ren_d;
      tgt_wen    <= wen_d;
      scan_rdata <= rdata_d;
      scan_ready <= ready_d;
      scan_err   <= err_d;
      scan_drop  <= drop_d;
`ifdef SCAN_MUX_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_scan_target_mux.sv
// Self-checking bench for scan_target_mux: directed scenarios plus randomized transactions
// compared against a transaction-level expectation model. Timeout checks need SCAN_MUX_TIMEOUT_EN.
module tb_scan_target_mux;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_ren = 1'b0, scan_wen = 1'b0;
  logic [11:0]  scan_addr = '0;
  logic [31:0]  scan_wdata = '0;
  logic [31:0]  scan_rdata;
  logic         scan_ready, scan_err, scan_drop;
  logic [3:0]   tgt_ren, tgt_wen;
  logic [9:0]   tgt_addr;
  logic [31:0]  tgt_wdata;
  logic [127:0] tgt_rdata = '0;
  logic [3:0]   tgt_ready = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: last response data and sticky drop flag
  logic [31:0] exp_rdata = '0;
  logic        exp_drop  = 1'b0;

  scan_target_mux dut (
    .clk(clk), .rst(rst),
    .scan_ren(scan_ren), .scan_wen(scan_wen), .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_rdata(scan_rdata), .scan_ready(scan_ready), .scan_err(scan_err), .scan_drop(scan_drop),
    .tgt_ren(tgt_ren), .tgt_wen(tgt_wen), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
    .tgt_rdata(tgt_rdata), .tgt_ready(tgt_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: request, strobe check, ready after 'delay' cycles, response check.
  task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int delay, input bit extra,
                         input logic [3:0] stray);
    logic [1:0]  sel;
    logic [3:0]  mask;
    int          extra_at;
    sel  = addr[11:10];
    mask = 4'b0001 << sel;
    for (int k = 0; k < 4; k++) tgt_rdata[k*32 +: 32] = (k == int'(sel)) ? rd : $urandom;
    scan_addr  = addr;
    scan_wdata = wd;
    scan_ren   = !wr;
    scan_wen   = wr;
    step();
    scan_ren = 1'b0;
    scan_wen = 1'b0;
    n_checks++;
    if (tgt_ren !== (wr ? 4'b0 : mask) || tgt_wen !== (wr ? mask : 4'b0)) begin
      n_fail++;
      $display("FAIL strobe: got ren=%b wen=%b want ren=%b wen=%b", tgt_ren, tgt_wen,
               wr ? 4'b0 : mask, wr ? mask : 4'b0);
    end
    n_checks++;
    if (tgt_addr !== addr[9:0] || tgt_wdata !== wd || scan_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL issue_bus: got addr=%h wdata=%h rdy=%b want addr=%h wdata=%h rdy=0",
               tgt_addr, tgt_wdata, scan_ready, addr[9:0], wd);
    end
    if (!wr) exp_rdata = rd;
    extra_at = (delay > 0) ? 1 : 0;
    for (int i = 0; i <= delay; i++) begin
      tgt_ready = stray & ~mask;
      if (i == delay) tgt_ready = tgt_ready | mask;
      if (extra && i == extra_at) begin
        scan_ren  = 1'b1;
        scan_addr = 12'($urandom);
        exp_drop  = 1'b1;
      end
      step();
      scan_ren = 1'b0;
      if (i < delay) begin
        n_checks++;
        if (scan_ready !== 1'b0 || tgt_ren !== 4'b0 || tgt_wen !== 4'b0) begin
          n_fail++;
          $display("FAIL wait_quiet: got rdy=%b ren=%b wen=%b want 0,0000,0000",
                   scan_ready, tgt_ren, tgt_wen);
        end
      end else begin
        n_checks++;
        if (scan_ready !== 1'b1 || scan_err !== 1'b0) begin
          n_fail++;
          $display("FAIL resp_flags: got rdy=%b err=%b want rdy=1 err=0", scan_ready, scan_err);
        end
        n_checks++;
        if (scan_rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL resp_data: got %h want %h", scan_rdata, exp_rdata);
        end
        n_checks++;
        if (scan_drop !== exp_drop || tgt_addr !== addr[9:0] || tgt_wdata !== wd) begin
          n_fail++;
          $display("FAIL resp_hold: got drop=%b addr=%h wdata=%h want drop=%b addr=%h wdata=%h",
                   scan_drop, tgt_addr, tgt_wdata, exp_drop, addr[9:0], wd);
        end
      end
    end
    tgt_ready = '0;
    step();
    n_checks++;
    if (scan_ready !== 1'b0 || scan_rdata !== exp_rdata) begin
      n_fail++;
      $display("FAIL resp_pulse: got rdy=%b data=%h want rdy=0 data=%h",
               scan_ready, scan_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scan_ren = 1'b1;
    scan_addr = 12'hC05;
    tgt_ready = 4'hF;
    step();
    step();
    n_checks++;
    if ({scan_rdata, scan_ready, scan_err, scan_drop, tgt_ren, tgt_wen, tgt_addr, tgt_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdata=%h rdy=%b err=%b drop=%b ren=%b wen=%b addr=%h wdata=%h want all 0",
               scan_rdata, scan_ready, scan_err, scan_drop, tgt_ren, tgt_wen, tgt_addr, tgt_wdata);
    end
    scan_ren = 1'b0;
    tgt_ready = '0;
    rst = 1'b0;
    step();
    n_checks++;
    if (tgt_ren !== 4'b0 || scan_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got ren=%b rdy=%b want 0000,0", tgt_ren, scan_ready);
    end
  endtask

  task automatic test_read_min();
    run_txn(1'b0, 12'hC05, 32'h0, 32'h1234_5678, 0, 1'b0, 4'b0);
  endtask

  task automatic test_write_delay();
    run_txn(1'b1, 12'h010, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 3, 1'b0, 4'b0110);
  endtask

  task automatic test_drop();
    run_txn(1'b0, 12'h4A7, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 4'b0);
  endtask

  task automatic test_both();
    int seen_at = 0;
    bit strobed = 1'b0;
    scan_ren = 1'b1;
    scan_wen = 1'b1;
    scan_addr = 12'h8F0;
    step();
    scan_ren = 1'b0;
    scan_wen = 1'b0;
    for (int c = 1; c <= 4 && seen_at == 0; c++) begin
      if (tgt_ren !== 4'b0 || tgt_wen !== 4'b0) strobed = 1'b1;
      if (scan_ready === 1'b1) begin
        seen_at = c;
        n_checks++;
        if (scan_err !== 1'b1 || scan_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL both_resp: got err=%b data=%h want err=1 data=0", scan_err, scan_rdata);
        end
      end else begin
        step();
      end
    end
    exp_rdata = '0;
    n_checks++;
    if (seen_at < 1 || seen_at > 2 || strobed) begin
      n_fail++;
      $display("FAIL both_timing: got ready_cycle=%0d strobed=%b want 1..2 and no strobe", seen_at, strobed);
    end
    step();
    step();
  endtask

  task automatic test_rst_mid();
    scan_ren = 1'b1;
    scan_addr = 12'h833;
    step();
    scan_ren = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_rdata = '0;
    exp_drop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tgt_ready = 4'b0100;
      step();
      n_checks++;
      if ({scan_rdata, scan_ready, scan_err, scan_drop, tgt_ren, tgt_wen, tgt_addr, tgt_wdata} !== '0) begin
        n_fail++;
        $display("FAIL abandoned: got rdata=%h rdy=%b err=%b drop=%b ren=%b wen=%b addr=%h wdata=%h want all 0",
                 scan_rdata, scan_ready, scan_err, scan_drop, tgt_ren, tgt_wen, tgt_addr, tgt_wdata);
      end
    end
    tgt_ready = '0;
    run_txn(1'b0, 12'h812, 32'h0, 32'hCAFE_0001, 1, 1'b0, 4'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom), 12'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
              ($urandom_range(0, 3) == 0), 4'($urandom));
    end
  endtask

`ifdef SCAN_MUX_TIMEOUT_EN
  task automatic test_timeout();
    int seen_at = 0;
    scan_ren = 1'b1;
    scan_addr = 12'hA21;
    step();
    scan_ren = 1'b0;
    tgt_ready = 4'b0010;
    for (int c = 1; c <= 30 && seen_at == 0; c++) begin
      step();
      if (scan_ready === 1'b1) begin
        seen_at = c;
        n_checks++;
        if (scan_err !== 1'b1 || scan_rdata !== 32'h0) begin
          n_fail++;
          $display("FAIL timeout_resp: got err=%b data=%h want err=1 data=0", scan_err, scan_rdata);
        end
      end
    end
    tgt_ready = '0;
    exp_rdata = '0;
    n_checks++;
    if (seen_at != 15) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles after strobe want 15", seen_at);
    end
    step();
    run_txn(1'b0, 12'hA22, 32'h0, 32'h7777_1111, 14, 1'b0, 4'b0001);
  endtask
`endif

  initial begin
    test_reset();
    test_read_min();
    test_write_delay();
    test_drop();
    test_both();
    test_rst_mid();
    test_random();
`ifdef SCAN_MUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
